// File: rtl/aesha_pkg.sv
// rtl/aesha_pkg.sv - shared constants, byte type, row-offset and row-parity helpers (AESHA_SR_PARITY_EN)
package aesha_pkg;

    localparam int NB_MIN = 4;
    localparam int NB_MAX = 8;
    localparam int ROWS   = 4;

    typedef logic [7:0] byte_t;

    // Rijndael row shift: the 256-bit block pushes rows 2 and 3 one column further.
    function automatic int sr_offset(input int nb, input int row);
        return (nb == 8 && row >= 2) ? row + 1 : row;
    endfunction

    // XOR of all column words gives one parity byte per row, invariant under ShiftRows.
    function automatic logic [31:0] state_par(input logic [32*NB_MAX-1:0] st, input int nb);
        logic [31:0] p;
        p = '0;
        for (int c = 0; c < nb; c++) begin
            p = p ^ st[32*nb-1-32*c -: 32];
        end
        return p;
    endfunction

endpackage

// File: rtl/aesha_shiftrows_pipe_if.sv
// rtl/aesha_shiftrows_pipe_if.sv - input/output beat handshake bundle of the ShiftRows stage
interface aesha_shiftrows_pipe_if #(
    parameter int W     = 128,
    parameter int TAG_W = 4
);
    logic             i_valid;
    logic             o_ready;
    logic             i_enc_or_dec;
    logic [W-1:0]     i_data;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [W-1:0]     o_data;
    logic [TAG_W-1:0] o_tag;

    modport master (
        output i_valid, i_enc_or_dec, i_data, i_tag, i_ready,
        input  o_ready, o_valid, o_data, o_tag
    );

    modport slave (
        input  i_valid, i_enc_or_dec, i_data, i_tag, i_ready,
        output o_ready, o_valid, o_data, o_tag
    );
endinterface

// File: rtl/aesha_sr_perm.sv
// rtl/aesha_sr_perm.sv - combinational ShiftRows / InvShiftRows byte permutation for NB columns
module aesha_sr_perm
    import aesha_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic            i_dec,
    input  logic [32*NB-1:0] i_state,
    output logic [32*NB-1:0] o_state
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S       = sr_offset(NB, r);
            localparam int ENC_SRC = (c + S) % NB;
            localparam int DEC_SRC = (c - S + NB) % NB;
            byte_t enc_b;
            byte_t dec_b;
            assign enc_b = i_state[32*NB-1-32*ENC_SRC-8*r -: 8];
            assign dec_b = i_state[32*NB-1-32*DEC_SRC-8*r -: 8];
            assign o_state[32*NB-1-32*c-8*r -: 8] = i_dec ? dec_b : enc_b;
        end
    end

endmodule

// File: rtl/aesha_shiftrows_pipe.sv
// rtl/aesha_shiftrows_pipe.sv - registered (Inv)ShiftRows stage with 2-entry skid buffer; optional AESHA_SR_PARITY_EN
module aesha_shiftrows_pipe
    import aesha_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    aesha_shiftrows_pipe_if.slave  bus,
    output logic                   o_par_err
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aesha_shiftrows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0]     perm_data;
    logic [W-1:0]     data_q [2];
    logic [W-1:0]     data_d [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic [TAG_W-1:0] tag_d  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    aesha_sr_perm #(.NB(NB)) u_perm (
        .i_dec   (bus.i_enc_or_dec),
        .i_state (bus.i_data),
        .o_state (perm_data)
    );

    // Outputs are forced quiet while reset is held, not only after the reset edge.
    assign bus.o_ready = (count_q != 2'd2) & ~i_reset;
    assign bus.o_valid = (count_q != 2'd0) & ~i_reset;
    assign bus.o_data  = i_reset ? '0 : data_q[rd_ptr_q];
    assign bus.o_tag   = i_reset ? '0 : tag_q[rd_ptr_q];

    assign push = bus.i_valid & bus.o_ready & ~i_flush;
    assign pop  = bus.o_valid & bus.i_ready;

    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            data_d[wr_ptr_q] = perm_data;
            tag_d[wr_ptr_q]  = bus.i_tag;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (i_flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q   <= '{default: '0};
            tag_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            data_q   <= data_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef AESHA_SR_PARITY_EN
    logic [31:0] par_q [2];
    logic [31:0] par_d [2];
    logic        par_err_q, par_err_d;

    always_comb begin
        par_d     = par_q;
        par_err_d = par_err_q;
        if (push) begin
            par_d[wr_ptr_q] = state_par((32*NB_MAX)'(bus.i_data), NB);
        end
        if (pop && (state_par((32*NB_MAX)'(data_q[rd_ptr_q]), NB) != par_q[rd_ptr_q])) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            par_q     <= '{default: '0};
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end

    assign o_par_err = par_err_q & ~i_reset;
`else
    assign o_par_err = 1'b0;
`endif

endmodule
